// File: rtl/exec_control_fsm.sv
// Execute-stage sequencer: latches one decoded instruction, resolves it in EXEC,
// runs its memory access in MEM if it has one, then writes back and redirects in WB.
module exec_control_fsm #(
  parameter int XLEN        = 32,
  parameter int PC_INC      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              alu_en,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic              rf_wr_en,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              jump_en,
  output logic [XLEN-1:0]   jump_target,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        state_dbg
);

  localparam int BEW  = XLEN / 8;
  localparam int OFFW = (XLEN == 64) ? 3 : 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]      state;
  logic [6:0]      l_opcode;
  logic [2:0]      l_funct3;
  logic [4:0]      l_rd;
  logic [XLEN-1:0] l_rs1, l_rs2, l_imm, l_pc;

  logic [XLEN-1:0] r_result, r_target, r_addr, r_store_data;
  logic [BEW-1:0]  r_be;
  logic            r_err, r_writer, r_jump, r_load;
  logic [7:0]      wait_cnt;

  logic [XLEN-1:0] eff_addr, d_result, d_target, d_wdata;
  logic [OFFW-1:0] off;
  logic [BEW-1:0]  d_be;
  logic            d_illegal, d_misaligned, d_load, d_store, d_writer, d_jump;
  logic [XLEN-1:0] ld_shift, ld_data;
  logic            in_mem;

  // Decode of the latched instruction; only consumed while in EXEC.
  always_comb begin
    eff_addr     = l_rs1 + l_imm;
    off          = eff_addr[OFFW-1:0];
    d_result     = '0;
    d_target     = l_pc + l_imm;
    d_wdata      = '0;
    d_be         = '0;
    d_illegal    = 1'b0;
    d_misaligned = 1'b0;
    d_load       = 1'b0;
    d_store      = 1'b0;
    d_writer     = 1'b0;
    d_jump       = 1'b0;
    case (l_opcode)
      OP_LOAD: begin
        d_load   = 1'b1;
        d_writer = 1'b1;
        case (l_funct3)
          3'b000, 3'b100: d_misaligned = 1'b0;
          3'b001, 3'b101: d_misaligned = eff_addr[0];
          3'b010:         d_misaligned = eff_addr[1:0] != 2'b00;
          3'b110: begin
            d_illegal    = (XLEN != 64);
            d_misaligned = eff_addr[1:0] != 2'b00;
          end
          3'b011: begin
            d_illegal    = (XLEN != 64);
            d_misaligned = eff_addr[2:0] != 3'b000;
          end
          default: d_illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        d_store = 1'b1;
        case (l_funct3)
          3'b000: begin
            d_wdata = {BEW{l_rs2[7:0]}};
            d_be    = BEW'(1) << off;
          end
          3'b001: begin
            d_misaligned = eff_addr[0];
            d_wdata      = {(XLEN/16){l_rs2[15:0]}};
            d_be         = BEW'(3) << off;
          end
          3'b010: begin
            d_misaligned = eff_addr[1:0] != 2'b00;
            d_wdata      = {(XLEN/32){l_rs2[31:0]}};
            d_be         = BEW'(15) << off;
          end
          3'b011: begin
            d_illegal    = (XLEN != 64);
            d_misaligned = eff_addr[2:0] != 3'b000;
            d_wdata      = l_rs2;
            d_be         = '1;
          end
          default: d_illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        case (l_funct3)
          3'b000:  d_jump = l_rs1 == l_rs2;
          3'b001:  d_jump = l_rs1 != l_rs2;
          3'b100:  d_jump = $signed(l_rs1) <  $signed(l_rs2);
          3'b101:  d_jump = $signed(l_rs1) >= $signed(l_rs2);
          3'b110:  d_jump = l_rs1 <  l_rs2;
          3'b111:  d_jump = l_rs1 >= l_rs2;
          default: d_illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        d_writer = 1'b1;
        d_jump   = 1'b1;
        d_result = l_pc + XLEN'(PC_INC);
      end
      OP_JALR: begin
        d_illegal = l_funct3 != 3'b000;
        d_writer  = 1'b1;
        d_jump    = 1'b1;
        d_target  = {eff_addr[XLEN-1:1], 1'b0};
        d_result  = l_pc + XLEN'(PC_INC);
      end
      OP_LUI: begin
        d_writer = 1'b1;
        d_result = l_imm;
      end
      OP_AUIPC: begin
        d_writer = 1'b1;
        d_result = l_pc + l_imm;
      end
      OP_IMM, OP_REG: begin
        d_writer = 1'b1;
        d_result = alu_result;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Load lane extraction from the latched effective address.
  always_comb begin
    ld_shift = mem_rdata >> {r_addr[OFFW-1:0], 3'b000};
    case (l_funct3)
      3'b000:  ld_data = XLEN'($signed(ld_shift[7:0]));
      3'b001:  ld_data = XLEN'($signed(ld_shift[15:0]));
      3'b010:  ld_data = XLEN'($signed(ld_shift[31:0]));
      3'b100:  ld_data = XLEN'(ld_shift[7:0]);
      3'b101:  ld_data = XLEN'(ld_shift[15:0]);
      3'b110:  ld_data = XLEN'(ld_shift[31:0]);
      default: ld_data = ld_shift;
    endcase
  end

  // Memory handshake: mem_rd_en/mem_wr_en is the valid, mem_ready the ready;
  // the access completes on the edge where both are high, and address, data
  // and byte enables hold steady until then (or until the timeout fires).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      l_opcode     <= '0;
      l_funct3     <= '0;
      l_rd         <= '0;
      l_rs1        <= '0;
      l_rs2        <= '0;
      l_imm        <= '0;
      l_pc         <= '0;
      r_result     <= '0;
      r_target     <= '0;
      r_addr       <= '0;
      r_store_data <= '0;
      r_be         <= '0;
      r_err        <= 1'b0;
      r_writer     <= 1'b0;
      r_jump       <= 1'b0;
      r_load       <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          l_opcode <= opcode;
          l_funct3 <= funct3;
          l_rd     <= rd;
          l_rs1    <= rs1_val;
          l_rs2    <= rs2_val;
          l_imm    <= imm;
          l_pc     <= pc;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          r_err        <= d_illegal | d_misaligned;
          r_writer     <= d_writer;
          r_jump       <= d_jump;
          r_target     <= d_target;
          r_result     <= d_result;
          r_addr       <= eff_addr;
          r_store_data <= d_wdata;
          r_be         <= d_be;
          r_load       <= d_load;
          wait_cnt     <= '0;
          state        <= ((d_load | d_store) && !d_illegal && !d_misaligned) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (r_load) r_result <= ld_data;
            state <= S_WB;
          end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
            r_err <= 1'b1;
            state <= S_WB;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_mem      = state == S_MEM;
  assign busy        = state != S_IDLE;
  assign done        = state == S_WB;
  assign err         = done & r_err;
  assign alu_en      = (state == S_EXEC) && (l_opcode == OP_IMM || l_opcode == OP_REG ||
                                             l_opcode == OP_LUI || l_opcode == OP_AUIPC);
  assign mem_rd_en   = in_mem & r_load;
  assign mem_wr_en   = in_mem & ~r_load;
  assign mem_addr    = in_mem ? r_addr : '0;
  assign mem_wdata   = mem_wr_en ? r_store_data : '0;
  assign mem_be      = mem_wr_en ? r_be : '0;
  assign rf_wr_en    = done & r_writer & ~r_err & (l_rd != 5'd0);
  assign rf_waddr    = rf_wr_en ? l_rd : '0;
  assign rf_wdata    = rf_wr_en ? r_result : '0;
  assign jump_en     = done & r_jump & ~r_err;
  assign jump_target = jump_en ? r_target : '0;
  assign state_dbg   = state;

endmodule

// File: tb/tb_exec_control_fsm.sv
// Bench for exec_control_fsm (XLEN=32): directed instruction vectors checked every
// cycle against a transaction-level model, plus literal expectations per vector.
module tb_exec_control_fsm;
  localparam int XLEN = 32;
  localparam int PCI  = 4;
  localparam int TMO  = 15;
  localparam int NA   = 1000;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, OPI = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111, AUI = 7'b0010111, BR = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;

  logic clk = 1'b0, rst, start, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [31:0] rs1_val, rs2_val, imm, pc, alu_result, mem_rdata;
  logic alu_en, mem_rd_en, mem_wr_en, rf_wr_en, jump_en, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, rf_wdata, jump_target;
  logic [3:0] mem_be;
  logic [4:0] rf_waddr;
  logic [1:0] state_dbg;

  exec_control_fsm #(.XLEN(XLEN), .PC_INC(PCI), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3), .rd(rd),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .alu_en(alu_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .rf_wr_en(rf_wr_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .jump_en(jump_en),
    .jump_target(jump_target), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          alu;
    bit          to_mem;
    int          n_mem;
    bit          rd_en;
    bit          wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    bit          jmp;
    logic [31:0] target;
    bit          err;
    int          done_c;
  } exp_t;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, abort_c = NA, seen_done_c = -1, rd_cnt = 0, rf_cnt = 0;
  bit act = 0, seen_jump = 0, seen_err = 0;
  logic [31:0] last_rf = 0, last_wdata = 0, last_jt = 0;
  logic [3:0] last_be = 0;
  exp_t cur;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Instruction-level outcome: what each instruction must do, and how many cycles it takes.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdi,
                                 input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] im,
                                 input logic [31:0] pcv, input logic [31:0] alu,
                                 input logic [31:0] rdat, input int w);
    exp_t e;
    logic [31:0] a, res;
    longint v;
    int size, off;
    bit legal, writer, is_ld, is_st, mis;
    e = '{default: 0};
    a = a1 + im;
    res = 0; size = 1; legal = 1; writer = 0; is_ld = 0; is_st = 0;
    case (op)
      OPI, 7'b0110011: begin e.alu = 1; writer = 1; res = alu; end
      LUI:  begin e.alu = 1; writer = 1; res = im; end
      AUI:  begin e.alu = 1; writer = 1; res = pcv + im; end
      JAL:  begin writer = 1; e.jmp = 1; e.target = pcv + im; res = pcv + PCI; end
      JALR: begin legal = (f3 == 0); writer = 1; e.jmp = 1; e.target = a & ~32'h1; res = pcv + PCI; end
      BR: begin
        e.target = pcv + im;
        case (f3)
          3'd0: e.jmp = a1 == a2;
          3'd1: e.jmp = a1 != a2;
          3'd4: e.jmp = int'(a1) < int'(a2);
          3'd5: e.jmp = int'(a1) >= int'(a2);
          3'd6: e.jmp = longint'(a1) < longint'(a2);
          3'd7: e.jmp = longint'(a1) >= longint'(a2);
          default: legal = 0;
        endcase
      end
      LD: begin
        is_ld = 1; writer = 1;
        case (f3)
          3'd0, 3'd4: size = 1;
          3'd1, 3'd5: size = 2;
          3'd2:       size = 4;
          default:    legal = 0;
        endcase
      end
      ST: begin
        is_st = 1;
        case (f3)
          3'd0: size = 1;
          3'd1: size = 2;
          3'd2: size = 4;
          default: legal = 0;
        endcase
      end
      default: legal = 0;
    endcase
    mis = (is_ld || is_st) && legal && (int'(a[2:0]) % size != 0);
    e.err = !legal || mis;
    e.to_mem = (is_ld || is_st) && !e.err;
    if (e.to_mem) begin
      e.n_mem = (w < TMO) ? w + 1 : TMO;
      e.err = (w >= TMO);
      e.rd_en = is_ld;
      e.wr_en = is_st;
    end
    e.addr = a;
    off = int'(a[1:0]);
    for (int ln = 0; ln < 4; ln++) begin
      e.be[ln] = is_st && ln >= off && ln < off + size;
      e.wdata[8*ln +: 8] = a2[8*(ln % size) +: 8];
    end
    if (is_ld) begin
      v = 0;
      for (int k = 0; k < size; k++) v = v | (longint'(rdat[8*(off+k) +: 8]) << (8*k));
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
      res = v[31:0];
    end
    e.rf_we = writer && rdi != 0 && !e.err;
    e.rf_addr = rdi;
    e.rf_data = res;
    e.jmp = e.jmp && !e.err;
    e.done_c = 2 + e.n_mem;
    return e;
  endfunction

  // Per-cycle compare: cycle 0 presents start, cycle 1 is EXEC, MEM follows, WB at done_c.
  always @(negedge clk) begin : cmp
    bit live, in_mem, wb;
    logic [36:0] got;
    if (act) begin
      live   = cyc >= 1 && cyc <= cur.done_c && cyc <= abort_c;
      in_mem = live && cur.to_mem && cyc >= 2 && cyc <= 1 + cur.n_mem;
      wb     = live && cyc == cur.done_c;
      chk("busy", busy, live);
      chk("alu_en", alu_en, live && cyc == 1 && cur.alu);
      chk("mem_rd_en", mem_rd_en, in_mem && cur.rd_en);
      chk("mem_wr_en", mem_wr_en, in_mem && cur.wr_en);
      if (in_mem) chk("mem_addr", mem_addr, cur.addr);
      if (in_mem && cur.wr_en) begin
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("mem_be", 32'(mem_be), 32'(cur.be));
      end
      chk("done", done, wb);
      chk("err", err, wb && cur.err);
      chk("rf_wr_en", rf_wr_en, wb && cur.rf_we);
      chk("jump_en", jump_en, wb && cur.jmp);
      if (wb && cur.jmp) chk("jump_target", jump_target, cur.target);
      if (rf_wr_en) begin
        if (exp_q.size() == 0) chk("rf_unexpected_write", 32'(rf_waddr), 32'hFFFF_FFFF);
        else begin
          got = exp_q.pop_front();
          chk("rf_waddr", 32'(rf_waddr), 32'(got[36:32]));
          chk("rf_wdata", rf_wdata, got[31:0]);
        end
        last_rf = rf_wdata;
        rf_cnt++;
      end
      if (done) seen_done_c = cyc;
      if (err) seen_err = 1;
      if (jump_en) begin seen_jump = 1; last_jt = jump_target; end
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) begin last_be = mem_be; last_wdata = mem_wdata; end
    end
  end

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdi,
                     input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] im,
                     input logic [31:0] pcv, input logic [31:0] alu, input logic [31:0] rdat,
                     input int w, input bit noise, input bit hold, input int ab);
    exp_t e;
    e = model(op, f3, rdi, a1, a2, im, pcv, alu, rdat, w);
    if (e.rf_we && e.done_c <= ab) exp_q.push_back({e.rf_addr, e.rf_data});
    @(posedge clk); #1;
    cur = e; abort_c = ab; cyc = 0; act = 1;
    seen_done_c = -1; seen_jump = 0; seen_err = 0; rd_cnt = 0; rf_cnt = 0;
    rst = 1; start = 1; opcode = op; funct3 = f3; rd = rdi;
    rs1_val = a1; rs2_val = a2; imm = im; pc = pcv; alu_result = alu; mem_rdata = rdat;
    mem_ready = noise;
    for (int c = 1; c <= e.done_c + 1; c++) begin
      @(posedge clk); #1;
      cyc = c;
      start = hold && (c <= e.done_c);
      opcode = 7'($urandom); funct3 = 3'($urandom); rd = 5'($urandom);
      rs1_val = $urandom; rs2_val = $urandom; imm = $urandom; pc = $urandom;
      mem_ready = (e.to_mem && c == 2 + w) || (noise && c == 1);
      rst = (c == ab) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    rst = 0; start = 0; mem_ready = 0; opcode = 0; funct3 = 0; rd = 0;
    rs1_val = 0; rs2_val = 0; imm = 0; pc = 0; alu_result = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_rf_wr_en", rf_wr_en, 0);

    // addi accepted on the first edge with rst released
    run(OPI, 3'd0, 5'd5, 32'h11, 0, 32'h7, 32'h40, 32'h2A, 0, 0, 0, 0, NA);
    chk("addi_latency", seen_done_c, 2);
    chk("addi_rf", last_rf, 32'h2A);
    // lb with two wait cycles and a stray mem_ready during EXEC
    run(LD, 3'd0, 5'd7, 32'h100, 0, 32'h3, 32'h44, 0, 32'h8000_0000, 2, 1, 0, NA);
    chk("lb_model_addr", cur.addr, 32'h103);
    chk("lb_latency", seen_done_c, 5);
    chk("lb_rd_cycles", rd_cnt, 3);
    chk("lb_rf", last_rf, 32'hFFFF_FF80);
    run(ST, 3'd1, 5'd3, 32'h200, 32'h1234_ABCD, 32'h2, 0, 0, 0, 0, 0, 0, NA);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_no_rf", rf_cnt, 0);
    // blt with start held high while busy
    run(BR, 3'd4, 5'd1, 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h100, 0, 0, 0, 0, 1, NA);
    chk("blt_jump", seen_jump, 1);
    chk("blt_target", last_jt, 32'h110);
    run(BR, 3'd6, 5'd1, 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h100, 0, 0, 0, 0, 0, NA);
    chk("bltu_jump", seen_jump, 0);
    chk("bltu_latency", seen_done_c, 2);
    run(LD, 3'd2, 5'd8, 32'h100, 0, 32'h2, 0, 0, 32'h1111_1111, 0, 0, 0, NA);
    chk("lw_mis_latency", seen_done_c, 2);
    chk("lw_mis_err", seen_err, 1);
    chk("lw_mis_no_strobe", rd_cnt, 0);
    run(LD, 3'd2, 5'd8, 32'h300, 0, 0, 0, 0, 32'h2222_2222, 99, 0, 0, NA);
    chk("lw_tmo_latency", seen_done_c, 17);
    chk("lw_tmo_rd_cycles", rd_cnt, 15);
    chk("lw_tmo_err", seen_err, 1);
    chk("lw_tmo_no_rf", rf_cnt, 0);
    // reset during MEM
    run(LD, 3'd2, 5'd8, 32'h400, 0, 0, 0, 0, 32'h3333_3333, 99, 0, 0, 3);
    chk("abort_no_done", seen_done_c, 32'hFFFF_FFFF);
    chk("abort_rd_cycles", rd_cnt, 2);
    run(LD, 3'd4, 5'd9, 32'h500, 0, 32'h1, 0, 0, 32'h0000_F100, 1, 0, 0, NA);
    chk("lbu_latency", seen_done_c, 4);
    chk("lbu_rf", last_rf, 32'hF1);
    run(JAL, 3'd0, 5'd1, 0, 0, 32'h20, 32'h1000, 0, 0, 0, 0, 0, NA);
    chk("jal_rf", last_rf, 32'h1004);
    chk("jal_target", last_jt, 32'h1020);
    run(JALR, 3'd0, 5'd2, 32'h2001, 0, 32'h4, 32'h3000, 0, 0, 0, 0, 0, NA);
    chk("jalr_target", last_jt, 32'h2004);
    chk("jalr_rf", last_rf, 32'h3004);
    run(LUI, 3'd0, 5'd3, 0, 0, 32'h1234_5000, 0, 32'h9, 0, 0, 0, 0, NA);
    chk("lui_rf", last_rf, 32'h1234_5000);
    run(AUI, 3'd0, 5'd4, 0, 0, 32'h1000, 32'h10, 32'h9, 0, 0, 0, 0, NA);
    chk("auipc_rf", last_rf, 32'h1010);
    run(ST, 3'd0, 5'd0, 32'h203, 32'h0000_00EF, 0, 0, 0, 0, 1, 0, 0, NA);
    chk("sb_be", 32'(last_be), 32'h8);
    chk("sb_wdata", last_wdata, 32'hEFEF_EFEF);
    run(ST, 3'd2, 5'd0, 32'h208, 32'hDEAD_BEEF, 0, 0, 0, 0, 3, 0, 0, NA);
    chk("sw_latency", seen_done_c, 6);
    chk("sw_be", 32'(last_be), 32'hF);
    run(LD, 3'd1, 5'd10, 32'h600, 0, 32'h2, 0, 0, 32'h8001_0000, 0, 0, 0, NA);
    chk("lh_rf", last_rf, 32'hFFFF_8001);
    run(LD, 3'd5, 5'd10, 32'h600, 0, 32'h2, 0, 0, 32'h8001_0000, 0, 0, 0, NA);
    chk("lhu_rf", last_rf, 32'h8001);
    // ready arriving on the last allowed MEM cycle is still a normal completion
    run(LD, 3'd2, 5'd11, 32'h700, 0, 0, 0, 0, 32'h55AA_1234, 14, 0, 0, NA);
    chk("lw_late_latency", seen_done_c, 17);
    chk("lw_late_err", seen_err, 0);
    chk("lw_late_rf", last_rf, 32'h55AA_1234);
    run(7'b0000000, 3'd0, 5'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, NA);
    chk("illegal_err", seen_err, 1);
    run(LD, 3'd3, 5'd6, 32'h800, 0, 0, 0, 0, 0, 0, 0, 0, NA);
    chk("ld32_err", seen_err, 1);
    chk("ld32_no_strobe", rd_cnt, 0);
    run(JALR, 3'd1, 5'd6, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, NA);
    chk("jalr_f3_no_jump", seen_jump, 0);
    run(BR, 3'd0, 5'd0, 32'h55, 32'h55, 32'h8, 32'h20, 0, 0, 0, 0, 0, NA);
    chk("beq_jump", seen_jump, 1);
    run(BR, 3'd5, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h8, 32'h20, 0, 0, 0, 0, 0, NA);
    chk("bge_jump", seen_jump, 0);
    run(BR, 3'd7, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h8, 32'h20, 0, 0, 0, 0, 0, NA);
    chk("bgeu_jump", seen_jump, 1);
    run(OPI, 3'd0, 5'd0, 32'h1, 0, 32'h1, 0, 32'h77, 0, 0, 0, 0, NA);
    chk("x0_no_rf", rf_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      run((i % 2) ? ST : LD, 3'($urandom_range(0, 2)), 5'($urandom_range(1, 31)),
          32'h1000 + 32'($urandom_range(0, 63)), $urandom, 0, 0, 0, $urandom,
          $urandom_range(0, 4), 0, 0, NA);
    end
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    n_chk++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exec_control_fsm.md
EXEC_CONTROL_FSM -- requirements
Module: exec_control_fsm

Interface
REQ-001 Parameter XLEN, default 32; datapath width; legal values 32 or 64.
REQ-002 Parameter PC_INC, default 4; link and fall-through increment.
REQ-003 Parameter MEM_TIMEOUT, default 15; maximum wait cycles for mem_ready, range 1..255.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  decoded instruction valid; sampled only in IDLE.
REQ-007 opcode  in  7 / funct3  in  3 / rd  in  5  decoded fields.
REQ-008 rs1_val, rs2_val, imm, pc  in  XLEN  operands; imm is already sign-extended.
REQ-009 alu_result  in  XLEN  combinational ALU result, valid in EXEC.
REQ-010 mem_rdata  in  XLEN / mem_ready  in  1  memory read data and access completion.
REQ-011 alu_en  out  1  high in EXEC for OP, OP-IMM, LUI and AUIPC.
REQ-012 mem_addr, mem_wdata  out  XLEN / mem_be  out  XLEN/8 / mem_rd_en, mem_wr_en  out  1.
REQ-013 rf_wr_en  out  1 / rf_waddr  out  5 / rf_wdata  out  XLEN  register-file write port.
REQ-014 jump_en  out  1 / jump_target  out  XLEN  PC redirect.
REQ-015 busy, done, err  out  1  status flags.

Function
REQ-016 States: IDLE, EXEC, MEM, WB; one-hot or binary encoding is permitted.
REQ-017 IDLE: if start=1, latch all inputs, set busy=1 and go to EXEC; otherwise stay in IDLE.
REQ-018 start is ignored while busy=1; no queuing.
REQ-019 EXEC, 1 cycle:
- Loads and stores go to MEM.
- All other opcodes go to WB.
- Illegal opcode/funct3 goes to WB with err.
REQ-020 Effective address = rs1_val+imm, modulo 2^XLEN.
REQ-021 Misaligned access goes straight to WB with err=1 and no memory strobe. Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or double with addr[2:0]!=0.
REQ-022 MEM state:
- mem_rd_en or mem_wr_en stays high, with mem_addr, mem_wdata and mem_be stable, until mem_ready=1 is sampled; the next state is then WB.
- mem_ready is ignored outside MEM.
REQ-023 Timeout: if mem_ready has not been seen after MEM_TIMEOUT cycles in MEM, drop the strobe, go to WB, set err=1 and suppress rf write.
REQ-024 Store data and byte enables:
- sb: byte replicated across all lanes, mem_be=1<<addr[2:0] (XLEN=64) or 1<<addr[1:0] (XLEN=32).
- sh: halfword replicated, two-bit mask at the aligned offset.
- sw: word replicated, four-bit mask at the aligned offset.
- sd: full mask.
REQ-025 Loads select the addressed lane. lb, lh and lw sign-extend; lbu, lhu and lwu zero-extend; ld passes through.
REQ-026 funct3 011 (ld/sd) and lwu are legal only when XLEN=64; otherwise they are illegal (err).
REQ-027 Branches compare in EXEC; target = pc+imm.
- beq/bne: equality.
- blt/bge: signed compare.
- bltu/bgeu: unsigned compare.
REQ-028 jal: target = pc+imm. jalr: target = (rs1_val+imm) with bit0 cleared. Both write rd = pc+PC_INC.
REQ-029 lui: rd = imm. auipc: rd = pc+imm. OP and OP-IMM: rd = alu_result, captured in EXEC.
REQ-030 WB, 1 cycle:
- done=1 for one cycle.
- rf_wr_en=1 for writers only when rd!=0 and err=0.
- jump_en=1 for a taken branch, jal or jalr.
- Next state is IDLE; busy falls the following cycle.
REQ-031 Latency start->done: 2 cycles for non-memory, misaligned and illegal instructions; 3+W cycles for memory instructions, where W is the number of cycles mem_ready stayed low.
REQ-032 jump_en, rf_wr_en, done and err are single-cycle pulses; all strobe outputs are zero outside their own state.

Reset
REQ-033 rst=0 at a clock edge forces IDLE and clears every output to 0, including any in-flight MEM strobe; this takes priority over all other inputs.
REQ-034 The first start is accepted on the first edge with rst=1 and start=1.

Verification
REQ-035 XLEN=32. addi: start, opcode 0010011, rd=5, alu_result=0x2A -> rf_wr_en, rf_waddr=5, rf_wdata=0x2A and done, all 2 cycles after start.
REQ-036 lb: rs1_val=0x100, imm=3, mem_ready low for 2 cycles, mem_rdata=0x80000000 -> mem_addr=0x103, mem_rd_en held 3 cycles, rf_wdata=0xFFFFFF80, done at cycle 5.
REQ-037 sh: addr=0x202, rs2_val=0x1234ABCD -> mem_be=0b1100, mem_wdata=0xABCDABCD, no rf write.
REQ-038 blt: rs1_val=-1, rs2_val=1 -> jump_en=1. bltu with the same operands -> jump_en=0, done=1.
REQ-039 lw at addr 0x102 -> no mem_rd_en, err=1, done at cycle 2. lw with mem_ready held low -> err after 15 MEM cycles, no rf write.
REQ-040 rst=0 while in MEM -> mem_rd_en=0 on the next edge, state IDLE, busy=0; a following start runs normally.
